vga_rect_fill: RTL and testbench



---
 rtl/vga_rect_fill.sv | 153 +++++++++++++++
 tb/tb_vga_rect_fill.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/vga_rect_fill.sv
// vga_rect_fill: turns rectangle-fill commands into a one-pixel-per-cycle
// framebuffer write stream (320x200, 12-bit {B,G,R}, addr = y*H_RES + x).
// Optional build macro VGA_RECT_FILL_CLIP_EN: when defined, rectangles are
// clipped to the visible area; when undefined, w/h are used as given and
// addresses wrap modulo 2^16.
module vga_rect_fill #(
  parameter int H_RES = 320,
  parameter int V_RES = 200
) (
  input  logic        main_clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [8:0]  cmd_x,
  input  logic [7:0]  cmd_y,
  input  logic [8:0]  cmd_w,
  input  logic [7:0]  cmd_h,
  input  logic [11:0] cmd_color,
  output logic        do_write,
  output logic [15:0] write_addr,
  output logic [11:0] write_data,
  output logic        busy,
  output logic        done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  logic [0:0]  state;
  logic [15:0] row_base;   // address of the first pixel of the current row
  logic [8:0]  row_w;      // effective width, reloaded into col_cnt per row
  logic [8:0]  col_cnt;    // pixels still to issue in this row after the one on the outputs
  logic [7:0]  row_cnt;    // rows still to start after the current one

  logic [8:0]  w_eff;
  logic [7:0]  h_eff;
  logic        empty;
  logic [15:0] base_calc;

  logic [8:0]  nxt_col;
  logic [7:0]  nxt_row;
  logic        last;

  // y*H_RES built from shifted copies of y, one per set bit of the constant
  // (320 -> y<<8 + y<<6), so no multiplier is inferred.
  function automatic logic [15:0] mul_hres(input logic [7:0] y);
    logic [15:0] acc;
    acc = '0;
    for (int i = 0; i < 16; i++)
      if (H_RES[i]) acc = acc + (16'(y) << i);
    return acc;
  endfunction

  assign base_calc = mul_hres(cmd_y) + 16'(cmd_x);

`ifdef VGA_RECT_FILL_CLIP_EN
  logic [8:0] w_room;
  logic [7:0] h_room;

  // Clip width/height to what remains of the screen from (x, y)
  always_comb begin
    w_room = 9'(H_RES) - cmd_x;
    h_room = 8'(V_RES) - cmd_y;
    w_eff  = cmd_w;
    h_eff  = cmd_h;
    if (cmd_x >= 9'(H_RES))  w_eff = '0;
    else if (cmd_w > w_room) w_eff = w_room;
    if (cmd_y >= 8'(V_RES))  h_eff = '0;
    else if (cmd_h > h_room) h_eff = h_room;
  end
`else
  assign w_eff = cmd_w;
  assign h_eff = cmd_h;
`endif

  assign empty     = (w_eff == '0) || (h_eff == '0);
  assign cmd_ready = (state == IDLE) && !reset;
  assign busy      = (state == FILL);

  // Remaining-count bookkeeping for the pixel after the one now on the outputs
  always_comb begin
    last = (col_cnt == '0) && (row_cnt == '0);
    if (col_cnt != '0) begin
      nxt_col = col_cnt - 9'd1;
      nxt_row = row_cnt;
    end else begin
      nxt_col = row_w - 9'd1;
      nxt_row = row_cnt - 8'd1;
    end
  end

  // Command accept, pixel walk and registered write outputs
  always_ff @(posedge main_clk) begin
    if (reset) begin
      state      <= IDLE;
      do_write   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      done       <= 1'b0;
      row_base   <= '0;
      row_w      <= '0;
      col_cnt    <= '0;
      row_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          do_write <= 1'b0;
          done     <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            if (empty) begin
              // nothing to draw: acknowledge and stay idle
              done <= 1'b1;
            end else begin
              state      <= FILL;
              do_write   <= 1'b1;
              write_addr <= base_calc;
              write_data <= cmd_color;
              row_base   <= base_calc;
              row_w      <= w_eff;
              col_cnt    <= w_eff - 9'd1;
              row_cnt    <= h_eff - 8'd1;
              done       <= (w_eff == 9'd1) && (h_eff == 8'd1);
            end
          end
        end
        FILL: begin
          if (last) begin
            state    <= IDLE;
            do_write <= 1'b0;
            done     <= 1'b0;
          end else begin
            do_write <= 1'b1;
            col_cnt  <= nxt_col;
            row_cnt  <= nxt_row;
            done     <= (nxt_col == '0) && (nxt_row == '0);
            if (col_cnt != '0) begin
              write_addr <= write_addr + 16'd1;
            end else begin
              row_base   <= row_base + 16'(H_RES);
              write_addr <= row_base + 16'(H_RES);
            end
          end
        end
        default: begin
          state    <= IDLE;
          do_write <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_rect_fill.sv
// Bench for vga_rect_fill: directed and random rectangles compared against a
// pixel-list model (nested row/column loops over y*320+x).
module tb_vga_rect_fill;

  localparam int H_RES = 320;
  localparam int V_RES = 200;

  logic        main_clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [8:0]  cmd_x = '0;
  logic [7:0]  cmd_y = '0;
  logic [8:0]  cmd_w = '0;
  logic [7:0]  cmd_h = '0;
  logic [11:0] cmd_color = '0;
  logic        do_write;
  logic [15:0] write_addr;
  logic [11:0] write_data;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  vga_rect_fill #(.H_RES(H_RES), .V_RES(V_RES)) dut (
    .main_clk(main_clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color),
    .do_write(do_write), .write_addr(write_addr), .write_data(write_data),
    .busy(busy), .done(done)
  );

  always #5 main_clk = ~main_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected address list for a command, straight from the geometry rules
  task automatic model(input int x, input int y, input int w, input int h);
    int we, he;
`ifdef VGA_RECT_FILL_CLIP_EN
    we = (x >= H_RES) ? 0 : ((w < H_RES - x) ? w : H_RES - x);
    he = (y >= V_RES) ? 0 : ((h < V_RES - y) ? h : V_RES - y);
`else
    we = w;
    he = h;
`endif
    exp_q.delete();
    for (int r = 0; r < he; r++)
      for (int c = 0; c < we; c++)
        exp_q.push_back(((y + r) * H_RES + x + c) % 65536);
  endtask

  task automatic present(input int x, input int y, input int w, input int h, input int col);
    cmd_x = 9'(x); cmd_y = 8'(y); cmd_w = 9'(w); cmd_h = 8'(h);
    cmd_color = 12'(col);
    cmd_valid = 1'b1;
  endtask

  // Called right after a negedge with a command presented; returns just after the accept edge
  task automatic accept();
    int k = 0;
    while (!cmd_ready && k < 50) begin
      @(negedge main_clk);
      k++;
    end
    chk("accept_wait", 64'(k < 50), 64'd1);
    @(posedge main_clk);
    #1;
  endtask

  // Writes (or the bare done pulse) following an accept, one check per cycle
  task automatic expect_stream(input int col);
    int n = exp_q.size();
    if (n == 0) begin
      @(negedge main_clk);
      chk("empty_done", {61'd0, do_write, busy, done}, 64'b001);
    end else begin
      for (int i = 0; i < n; i++) begin
        @(negedge main_clk);
        chk($sformatf("write[%0d]", i),
            {33'd0, do_write, busy, done, write_addr, write_data},
            {33'd0, 1'b1, 1'b1, (i == n - 1), 16'(exp_q[i]), 12'(col)});
      end
    end
  endtask

  task automatic expect_idle();
    @(negedge main_clk);
    chk("idle_after", {60'd0, cmd_ready, do_write, busy, done}, 64'b1000);
  endtask

  task automatic issue(input int x, input int y, input int w, input int h, input int col);
    @(negedge main_clk);
    present(x, y, w, h, col);
    model(x, y, w, h);
    accept();
    cmd_valid = 1'b0;
    expect_stream(col);
    expect_idle();
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge main_clk);
    chk("reset_outputs", {30'd0, cmd_ready, do_write, busy, done, write_addr, write_data}, 64'd0);
    reset = 1'b0;
    @(negedge main_clk);
    chk("ready_after_reset", {63'd0, cmd_ready}, 64'd1);

    // single pixel
    issue(0, 0, 1, 1, 12'hF00);
    // small 3x2 block, explicit address expectations alongside the model
    model(10, 2, 3, 2);
    chk("model_650", 64'(exp_q[0]), 64'd650);
    chk("model_972", 64'(exp_q[5]), 64'd972);
    issue(10, 2, 3, 2, 12'h0A5);
    // bottom-right corner: clipped to 2 pixels or 20 wrapping writes
    issue(318, 199, 5, 4, 12'h3C7);
    // fully off-screen / zero-sized commands
    issue(320, 5, 4, 2, 12'h111);
    issue(5, 3, 4, 0, 12'h222);

    // empty command with valid held: next command taken in the done cycle
    @(negedge main_clk);
    present(7, 7, 0, 7, 12'h555);
    accept();
    present(4, 1, 2, 2, 12'h9AB);
    @(negedge main_clk);
    chk("empty_then_ready", {60'd0, cmd_ready, do_write, busy, done}, 64'b1001);
    @(posedge main_clk);
    #1;
    cmd_valid = 1'b0;
    model(4, 1, 2, 2);
    expect_stream(12'h9AB);
    expect_idle();

    // reset in the middle of a fill: only the first two writes appear
    @(negedge main_clk);
    present(0, 0, 8, 1, 12'h123);
    accept();
    cmd_valid = 1'b0;
    @(negedge main_clk);
    chk("abort_w0", {35'd0, do_write, write_addr, write_data}, {35'd0, 1'b1, 16'd0, 12'h123});
    @(negedge main_clk);
    chk("abort_w1", {35'd0, do_write, write_addr, write_data}, {35'd0, 1'b1, 16'd1, 12'h123});
    reset = 1'b1;
    @(negedge main_clk);
    chk("abort_reset", {30'd0, cmd_ready, do_write, busy, done, write_addr, write_data}, 64'd0);
    reset = 1'b0;
    @(negedge main_clk);
    chk("abort_ready", {62'd0, cmd_ready, do_write}, 64'b10);

    // random rectangles, some straddling the screen edges
    for (int t = 0; t < 30; t++) begin
      int rx, ry, rw, rh, rc;
      rx = $urandom_range(0, 330);
      ry = $urandom_range(0, 210);
      rw = $urandom_range(0, 12);
      rh = $urandom_range(0, 6);
      rc = $urandom_range(0, 4095);
      issue(rx, ry, rw, rh, rc);
    end

    // full screen
    issue(0, 0, 320, 200, 12'h7E1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
